multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control.sv | 183 ++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle control FSM for a small RV32I subset (ADDI, SLLI, SLT, LW, SW, NOP).
// Sequences the IF/ID/EXE/MEM/WB datapath strobes, traps on unsupported encodings, counts retirements.
module multi_cycle_control (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [6:0]  opCode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic [6:0]  ALUopCode,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    StIf   = 3'b000,
    StId   = 3'b001,
    StExe  = 3'b010,
    StMem  = 3'b011,
    StWb   = 3'b100,
    StTrap = 3'b111
  } state_e;

  typedef enum logic [2:0] {
    ClsNop, ClsAddi, ClsSlli, ClsSlt, ClsLw, ClsSw, ClsIll
  } cls_e;

  function automatic cls_e decode(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7);
    cls_e c;
    c = ClsIll;
    case (op)
      7'b0000000: c = ClsNop;
      7'b0010011: begin
        if (f3 == 3'b000) c = ClsAddi;
        else if (f3 == 3'b001 && f7 == 7'b0000000) c = ClsSlli;
      end
      7'b0110011: if (f3 == 3'b010 && f7 == 7'b0000000) c = ClsSlt;
      7'b0000011: if (f3 == 3'b010) c = ClsLw;
      7'b0100011: if (f3 == 3'b010) c = ClsSw;
      default:    c = ClsIll;
    endcase
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [2:0]  f3_q, f3_d;
  logic [6:0]  f7_q, f7_d;
  logic        illegal_q, illegal_d;
  logic [15:0] retired_q, retired_d;
  logic        retire;
  cls_e        id_cls, lat_cls;

  assign id_cls  = decode(opCode, funct3, funct7);
  assign lat_cls = decode(op_q, f3_q, f7_q);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIf;
      op_q      <= 7'd0;
      f3_q      <= 3'd0;
      f7_q      <= 7'd0;
      illegal_q <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      f3_q      <= f3_d;
      f7_q      <= f7_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = StIf;
    op_d      = op_q;
    f3_d      = f3_q;
    f7_d      = f7_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      StIf: state_d = StId;
      StId: begin
        // Fields are captured on every ID exit so later states never look at the live inputs.
        op_d = opCode;
        f3_d = funct3;
        f7_d = funct7;
        case (id_cls)
          ClsNop: begin
            state_d = StIf;
            retire  = 1'b1;
          end
          ClsIll: begin
            state_d   = StTrap;
            illegal_d = 1'b1;
          end
          default: state_d = StExe;
        endcase
      end
      StExe: state_d = (lat_cls == ClsLw || lat_cls == ClsSw) ? StMem : StWb;
      StMem: begin
        if (!mem_ready) begin
          state_d = StMem;
        end else if (lat_cls == ClsLw) begin
          state_d = StWb;
        end else begin
          state_d = StIf;
          retire  = 1'b1;
        end
      end
      StWb: begin
        state_d = StIf;
        retire  = 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StIf;
    endcase
    retired_d = retire ? retired_q + 16'd1 : retired_q;
  end

  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    ALUopCode = (state_q == StIf) ? 7'd0 : op_q;
    if (state_q == StExe || state_q == StMem || state_q == StWb) begin
      unique case (lat_cls)
        ClsSlli: begin ALUOp = 3'b001; ALUSrcB = 1'b1; end
        ClsSlt:  begin ALUOp = 3'b010; ALUSrcB = 1'b0; end
        ClsAddi, ClsLw, ClsSw: begin ALUOp = 3'b000; ALUSrcB = 1'b1; end
        default: begin ALUOp = 3'b000; ALUSrcB = 1'b0; end
      endcase
    end
    case (state_q)
      StIf: begin
        PCWrite = 1'b1;
        IRWrite = 1'b1;
      end
      StMem: begin
        MemRead  = (lat_cls == ClsLw);
        MemWrite = (lat_cls == ClsSw);
      end
      StWb: begin
        RegWrite = 1'b1;
        MemToReg = (lat_cls == ClsLw);
      end
      default: ;
    endcase
    // Reset silences the datapath immediately, without waiting for a clock edge.
    if (!Reset_n) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      MemToReg  = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'b000;
      ALUopCode = 7'd0;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: instruction-level model expands each instruction into its
// expected per-cycle outputs; a negedge process compares them, plus a few literal pins.
module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op_in;
  logic [2:0]  f3_in;
  logic [6:0]  f7_in;
  logic        mem_ready;
  logic        pcw, irw, rw, mr, mw, m2r, srcb, ill;
  logic [2:0]  aluop, st;
  logic [6:0]  aopc;
  logic [15:0] ret;

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .CLK       (clk),
    .Reset_n   (rst_n),
    .opCode    (op_in),
    .funct3    (f3_in),
    .funct7    (f7_in),
    .mem_ready (mem_ready),
    .PCWrite   (pcw),
    .IRWrite   (irw),
    .RegWrite  (rw),
    .MemRead   (mr),
    .MemWrite  (mw),
    .MemToReg  (m2r),
    .ALUSrcB   (srcb),
    .ALUOp     (aluop),
    .ALUopCode (aopc),
    .state     (st),
    .illegal   (ill),
    .retired   (ret)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw, irw, rw, mr, mw, m2r, srcb;
    logic [2:0]  aluop;
    logic [6:0]  aopc;
    logic        ill;
    logic [15:0] ret;
  } obs_t;

  obs_t  exp_o, act_o;
  assign act_o = {st, pcw, irw, rw, mr, mw, m2r, srcb, aluop, aopc, ill, ret};

  int    n_tests = 0;
  int    n_fail  = 0;
  bit    chk_en  = 1'b0;
  string tag     = "";

  // Literal-check mailbox, consumed by the compare process.
  int          lit_seq  = 0;
  int          lit_done = 0;
  string       lit_tag  = "";
  logic [36:0] lit_got, lit_want;

  // Instruction-level model state.
  logic [15:0] m_ret;
  logic        m_ill;
  logic [6:0]  m_lat;

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL %s @%0t: got %h required %h", tag, $time, act_o, exp_o);
      end
    end
    if (lit_seq != lit_done) begin
      n_tests++;
      if (lit_got !== lit_want) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", lit_tag, lit_got, lit_want);
      end
      lit_done = lit_seq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_lit(input string t, input logic [36:0] got, input logic [36:0] want);
    wait (lit_done == lit_seq);
    lit_tag  = t;
    lit_got  = got;
    lit_want = want;
    lit_seq++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t base(input logic [2:0] s);
    obs_t b;
    b      = '0;
    b.st   = s;
    b.aopc = (s == 3'd0) ? 7'd0 : m_lat;
    b.ill  = m_ill;
    b.ret  = m_ret;
    return b;
  endfunction

  // kind: 0 nop, 1 register-writing ALU op, 2 load, 3 store, 4 illegal
  task automatic classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          output int kind, output logic [2:0] aop, output logic sb);
    aop = 3'd0;
    sb  = 1'b0;
    if (op == 7'h00) kind = 0;
    else if (op == 7'h13 && f3 == 3'd0) begin kind = 1; sb = 1'b1; end
    else if (op == 7'h13 && f3 == 3'd1 && f7 == 7'd0) begin kind = 1; aop = 3'd1; sb = 1'b1; end
    else if (op == 7'h33 && f3 == 3'd2 && f7 == 7'd0) begin kind = 1; aop = 3'd2; end
    else if (op == 7'h03 && f3 == 3'd2) begin kind = 2; sb = 1'b1; end
    else if (op == 7'h23 && f3 == 3'd2) begin kind = 3; sb = 1'b1; end
    else kind = 4;
  endtask

  task automatic model_reset();
    m_ret = 16'd0;
    m_ill = 1'b0;
    m_lat = 7'd0;
  endtask

  // Runs one instruction from its IF cycle; abort_at >= 0 pulls reset in that MEM cycle.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int waits, input int abort_at);
    int         kind;
    logic [2:0] aop;
    logic       sb;
    classify(op, f3, f7, kind, aop, sb);
    exp_o = base(3'd0); exp_o.pcw = 1'b1; exp_o.irw = 1'b1; tag = "IF";
    op_in = 7'($urandom); f3_in = 3'($urandom); f7_in = 7'($urandom); mem_ready = 1'b1;
    tick();
    exp_o = base(3'd1); tag = "ID";
    op_in = op; f3_in = f3; f7_in = f7; mem_ready = 1'b1;
    tick();
    m_lat = op;
    if (kind == 0) begin m_ret++; return; end
    if (kind == 4) begin m_ill = 1'b1; return; end
    exp_o = base(3'd2); exp_o.aluop = aop; exp_o.srcb = sb; tag = "EXE";
    op_in = 7'($urandom); f3_in = 3'($urandom); f7_in = 7'($urandom); mem_ready = 1'b1;
    tick();
    if (kind >= 2) begin
      for (int i = 0; i <= waits; i++) begin
        exp_o = base(3'd3); exp_o.aluop = aop; exp_o.srcb = sb;
        exp_o.mr = (kind == 2); exp_o.mw = (kind == 3); tag = "MEM";
        mem_ready = (i == waits);
        if (i == abort_at) begin
          mem_ready = 1'b0;
          @(negedge clk);
          #1;
          rst_n = 1'b0;
          #1;
          chk_en = 1'b0;
          check_lit("abort_in_mem", act_o, '0);
          @(posedge clk);
          #1;
          check_lit("abort_no_wb", act_o, '0);
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          model_reset();
          chk_en = 1'b1;
          return;
        end
        tick();
      end
      if (kind == 3) begin m_ret++; return; end
    end
    exp_o = base(3'd4); exp_o.aluop = aop; exp_o.srcb = sb;
    exp_o.rw = 1'b1; exp_o.m2r = (kind == 2); tag = "WB";
    mem_ready = 1'b1;
    tick();
    m_ret++;
  endtask

  initial begin
    rst_n = 1'b0;
    op_in = 7'd0; f3_in = 3'd0; f7_in = 7'd0; mem_ready = 1'b0;
    model_reset();
    #3;
    check_lit("reset_hold", act_o, '0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_instr(7'b0010011, 3'b000, 7'h55, 0, -1);                    // ADDI
    check_lit("addi_retired", {21'd0, ret}, 37'd1);
    run_instr(7'b0000011, 3'b010, 7'h00, 3, -1);                    // LW, 3 wait cycles
    check_lit("lw_retired", {21'd0, ret}, 37'd2);
    run_instr(7'b0110011, 3'b010, 7'h00, 0, -1);                    // SLT
    run_instr(7'b0100011, 3'b010, 7'h00, 0, -1);                    // SW, ready at once
    check_lit("slt_sw_retired", {21'd0, ret}, 37'd4);
    run_instr(7'b0010011, 3'b001, 7'h00, 0, -1);                    // SLLI
    run_instr(7'b0000000, 3'b101, 7'h7F, 0, -1);                    // NOP
    check_lit("nop_retired", {21'd0, ret}, 37'd6);

    // Preload the counter near the top instead of issuing 65535 NOPs.
    force dut.retired_q = 16'hFFFD;
    m_ret = 16'hFFFD;
    fork
      begin
        @(posedge clk);
        #2;
        release dut.retired_q;
      end
    join_none
    run_instr(7'b0000000, 3'b000, 7'h00, 0, -1);
    run_instr(7'b0000000, 3'b000, 7'h00, 0, -1);
    check_lit("retired_top", {21'd0, ret}, 37'h0FFFF);
    run_instr(7'b0000000, 3'b000, 7'h00, 0, -1);
    check_lit("retired_wrap", {21'd0, ret}, 37'd0);

    run_instr(7'b0100011, 3'b010, 7'h00, 4, 2);                     // SW aborted in MEM wait
    run_instr(7'b0010011, 3'b000, 7'h00, 0, -1);                    // ADDI after abort
    check_lit("post_abort_retired", {21'd0, ret}, 37'd1);

    run_instr(7'b1111111, 3'b000, 7'h00, 0, -1);                    // illegal -> TRAP
    for (int i = 0; i < 10; i++) begin
      exp_o = base(3'd7); tag = "TRAP";
      mem_ready = 1'($urandom);
      op_in = 7'($urandom);
      tick();
    end
    check_lit("trap_illegal", {36'd0, ill}, 37'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_en = 1'b0;
    check_lit("trap_reset", act_o, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    run_instr(7'b0000000, 3'b000, 7'h00, 0, -1);                    // NOP after trap clear

    wait (lit_done == lit_seq);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
